// File: rtl/rv32_lsu_pkg.sv
// Shared definitions for the RV32 load/store unit: FSM states, funct3
// encodings and the request legality/alignment rule.
package rv32_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // True when the request must be rejected without a bus access: an
  // unsupported funct3, or an access not aligned to its own size.
  function automatic logic is_misaligned(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic illegal;
    if (we) illegal = (funct3 > F3_SW);
    else    illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    return illegal
        || ((funct3[1:0] == 2'b01) && addr_lo[0])
        || ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/rv32_lsu_align.sv
// Byte-lane steering: byte enables and replicated write data for the bus,
// and lane extraction with sign/zero extension for returned load data.
module rv32_lsu_align
  import rv32_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Access size comes from funct3[1:0]; loads and stores share the mask.
  always_comb begin
    be         = 4'b0000;
    lane_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << offset;
        lane_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << offset;
        lane_wdata = {2{wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    shifted   = rdata >> {offset, 3'b000};
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   load_data = shifted;
      F3_LBU:  load_data = {24'd0, shifted[7:0]};
      F3_LHU:  load_data = {16'd0, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/rv32_lsu.sv
// RV32I load/store unit: accepts one core request at a time, issues a
// single word-aligned bus access, and returns one response per request.
module rv32_lsu
  import rv32_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misalign,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e    state;
  logic [CW-1:0] count;
  logic          we_q;
  logic [2:0]    funct3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be;
  logic [31:0]   lane_wdata;
  logic [31:0]   load_data;
  logic          timeout;

  assign req_ready = (state == IDLE);
  assign timeout   = (count == CW'(TIMEOUT_CYCLES - 1));

  // Bus address/data are held in the request registers, so they stay
  // stable until grant; they read as zero whenever no request is pending.
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be : '0;
  assign mem_wdata = mem_req ? lane_wdata : '0;

  rv32_lsu_align u_align (
    .funct3     (funct3_q),
    .offset     (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .be         (be),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  // Capture the request fields on accept.
  // NOTE: these datapath registers carry no reset; they only reach the
  // outputs through mem_req gating or the reset response registers.
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  // Request sequencing, timeout counting and registered bus/response outputs.
  // NOTE: all state here uses non-blocking assignments so every branch sees
  // the pre-edge values of count, state and the latched request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      count        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_misalign <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            count <= '0;
            if (is_misaligned(req_we, req_funct3, req_addr[1:0])) begin
              state        <= RESP;
              rsp_valid    <= 1'b1;
              rsp_misalign <= 1'b1;
            end else begin
              state   <= REQ;
              mem_req <= 1'b1;
              mem_we  <= req_we;
            end
          end
        end
        REQ: begin
          count <= count + 1'b1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (we_q) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else if (timeout) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end
        end
        WAIT: begin
          count <= count + 1'b1;
          if (mem_rvalid) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
          end else if (timeout) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end
        end
        RESP: begin
          state        <= IDLE;
          rsp_valid    <= 1'b0;
          rsp_rdata    <= '0;
          rsp_misalign <= 1'b0;
          rsp_err      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rv32_lsu.md
RV32_LSU -- requirements
Module: rv32_lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the bus cycles allowed in REQ+WAIT before an error response.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset; synchronous, active-low.
REQ-004 req_valid  input  1  SHALL indicate a core load/store request.
REQ-005 req_ready  output  1  SHALL indicate the LSU can accept a request.
REQ-006 req_we  input  1  SHALL select store (1) or load (0).
REQ-007 req_funct3  input  3  SHALL be the RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 req_addr  input  32  SHALL be the byte address from the ALU.
REQ-009 req_wdata  input  32  SHALL be the store data from register rs2.
REQ-010 rsp_valid  output  1  SHALL pulse one cycle per completed request.
REQ-011 rsp_rdata  output  32  SHALL be the extended load data; 0 for stores and errors.
REQ-012 rsp_misalign  output  1  SHALL flag a misaligned or illegal-funct3 request.
REQ-013 rsp_err  output  1  SHALL flag a bus timeout.
REQ-014 mem_req, mem_we  output  1 each  SHALL be the bus request and write strobe.
REQ-015 mem_addr  output  32  SHALL be the word-aligned address {req_addr[31:2],2'b00}.
REQ-016 mem_be, mem_wdata  output  4/32  SHALL be the byte enables and lane-replicated write data.
REQ-017 mem_gnt, mem_rvalid  input  1 each; mem_rdata  input  32  SHALL be the grant, read-valid and read data.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, RESP; req_ready=1 only in IDLE.
REQ-019 On req_valid&&req_ready the block SHALL latch we, funct3, addr and wdata.
REQ-020 Misalignment: halfword with addr[0]=1, word with addr[1:0]!=0, loads with funct3 011/110/111, stores with funct3>010; SHALL go IDLE->RESP, no bus access, rsp_misalign=1.
REQ-021 Aligned accept SHALL go to REQ; mem_req, mem_addr, mem_we, mem_be and mem_wdata SHALL stay stable until mem_gnt.
REQ-022 Store granted SHALL go REQ->RESP; load granted SHALL go REQ->WAIT.
REQ-023 In WAIT, mem_rvalid SHALL capture mem_rdata and go to RESP; mem_rvalid outside WAIT SHALL be ignored.
REQ-024 rsp_valid SHALL be 1 only in RESP, exactly one cycle; RESP SHALL return to IDLE.
REQ-025 Byte enables: SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111; loads SHALL drive the same mask.
REQ-026 Write data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-027 Load data SHALL be mem_rdata>>(8*addr[1:0]); LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged.
REQ-028 A timeout counter SHALL clear on accept and increment each cycle in REQ or WAIT.
REQ-029 When the counter reaches TIMEOUT_CYCLES, the block SHALL drop mem_req, go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-030 A grant or rvalid in the timeout cycle SHALL take precedence over the timeout.
REQ-031 Minimum latency: store accepted cycle N with gnt at N+1 SHALL give rsp_valid at N+2; load with rvalid at N+2 SHALL give rsp_valid at N+3.

Reset
REQ-032 While rst=0 at a clock edge: state IDLE, counter 0, all outputs 0 except req_ready=1 after release.
REQ-033 Reset mid-transaction SHALL abandon the request with no response; mem_req SHALL be 0 from the next edge.

Structure
REQ-034 Package rv32_lsu_pkg SHALL hold the FSM state enum and the funct3 load/store constants, shared with RV32_Controller.
REQ-035 Byte-lane mask, write replication and load extraction SHALL be one combinational sub-module rv32_lsu_align.

Verification
REQ-036 SW addr 0x100, data 0xDEADBEEF, gnt 1 cycle later -> be 4'b1111, mem_addr 0x100, rsp_valid at N+2.
REQ-037 SB addr 0x103, data 0x000000A5 -> be 4'b1000, mem_wdata 0xA5A5A5A5.
REQ-038 LB addr 0x102, mem_rdata 0x1280FF00 -> rsp_rdata 0xFFFFFF80; LBU -> 0x00000080.
REQ-039 LH addr 0x101 -> rsp_misalign=1 one cycle after accept; mem_req never asserted.
REQ-040 Load, gnt never asserted, TIMEOUT_CYCLES=4 -> rsp_err=1 after 4 REQ cycles; mem_req then 0.
REQ-041 Reset asserted in WAIT, then released -> no rsp_valid, req_ready=1, mem_req=0.
